// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and the pool1 sequencer state type.
// Pool1 uses this package for its default geometry and its FSM encoding.
package cnn_pkg;

  localparam int unsigned CNN_DATA_W  = 16;
  localparam int unsigned CNN_IN_DIM  = 24;
  localparam int unsigned CNN_OUT_DIM = CNN_IN_DIM / 2;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StWrite,
    StDone
  } pool1_state_t;

endpackage

// File: rtl/max4_signed.sv
// Combinational signed maximum of four values, built as a two-level compare tree.
// On a tie it returns the shared value; which input supplied it does not matter.
module max4_signed
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = CNN_DATA_W
) (
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  input  logic signed [DATA_W-1:0] i_c,
  input  logic signed [DATA_W-1:0] i_d,
  output logic signed [DATA_W-1:0] o_max
);

  logic signed [DATA_W-1:0] w_max_ab;
  logic signed [DATA_W-1:0] w_max_cd;

  assign w_max_ab = (i_a >= i_b) ? i_a : i_b;
  assign w_max_cd = (i_c >= i_d) ? i_c : i_d;
  assign o_max    = (w_max_ab >= w_max_cd) ? w_max_ab : w_max_cd;

endmodule

// File: rtl/pool1_sched.sv
// Sequencer for the 2x2 stride-2 max-pool after conv1: read window, wait latency, write max.
// Define POOL1_RELU_EN to clamp negative pooled values to zero before the write.
module pool1_sched
  import cnn_pkg::*;
#(
  parameter int unsigned IN_DIM    = CNN_IN_DIM,
  parameter int unsigned DATA_W    = CNN_DATA_W,
  parameter int unsigned RD_ADDR_W = 10,
  parameter int unsigned WR_ADDR_W = 8,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_rd_en,
  output logic        [RD_ADDR_W-1:0] o_rd_addr0,
  output logic        [RD_ADDR_W-1:0] o_rd_addr1,
  output logic        [RD_ADDR_W-1:0] o_rd_addr2,
  output logic        [RD_ADDR_W-1:0] o_rd_addr3,
  input  logic signed [DATA_W-1:0]    i_rd_data0,
  input  logic signed [DATA_W-1:0]    i_rd_data1,
  input  logic signed [DATA_W-1:0]    i_rd_data2,
  input  logic signed [DATA_W-1:0]    i_rd_data3,
  output logic                        o_wr_en,
  output logic        [WR_ADDR_W-1:0] o_wr_addr,
  output logic signed [DATA_W-1:0]    o_wr_data
);

  localparam int unsigned OUT_DIM = IN_DIM / 2;
  localparam int unsigned CNT_W   = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int unsigned LAT_W   = $clog2(RD_LAT) + 1;

  pool1_state_t r_state;
  logic [CNT_W-1:0] r_row;
  logic [CNT_W-1:0] r_col;
  logic [LAT_W-1:0] r_lat;
  logic r_busy;
  logic r_done;
  logic r_rd_en;
  logic r_wr_en;
  logic [RD_ADDR_W-1:0] r_rd_addr0;
  logic [RD_ADDR_W-1:0] r_rd_addr1;
  logic [RD_ADDR_W-1:0] r_rd_addr2;
  logic [RD_ADDR_W-1:0] r_rd_addr3;
  logic [WR_ADDR_W-1:0] r_wr_addr;
  logic signed [DATA_W-1:0] r_wr_data;

  logic w_col_last;
  logic w_last_win;
  logic [CNT_W-1:0] w_nxt_row;
  logic [CNT_W-1:0] w_nxt_col;
  logic [RD_ADDR_W-1:0] w_base;
  logic signed [DATA_W-1:0] w_max;
  logic signed [DATA_W-1:0] w_wr_val;

  assign w_col_last = (r_col == CNT_W'(OUT_DIM - 1));
  assign w_last_win = w_col_last && (r_row == CNT_W'(OUT_DIM - 1));

  // From IDLE the next window is always (0,0); otherwise advance in raster order.
  always_comb begin
    w_nxt_row = r_row;
    w_nxt_col = r_col + 1'b1;
    if (r_state == StIdle) begin
      w_nxt_row = '0;
      w_nxt_col = '0;
    end else if (w_col_last) begin
      w_nxt_row = r_row + 1'b1;
      w_nxt_col = '0;
    end
  end

  assign w_base = RD_ADDR_W'(2 * IN_DIM * 32'(w_nxt_row) + 2 * 32'(w_nxt_col));

  max4_signed #(
    .DATA_W(DATA_W)
  ) u_max4 (
    .i_a  (i_rd_data0),
    .i_b  (i_rd_data1),
    .i_c  (i_rd_data2),
    .i_d  (i_rd_data3),
    .o_max(w_max)
  );

`ifdef POOL1_RELU_EN
  assign w_wr_val = w_max[DATA_W-1] ? '0 : w_max;
`else
  assign w_wr_val = w_max;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_row      <= '0;
      r_col      <= '0;
      r_lat      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_en    <= 1'b0;
      r_wr_en    <= 1'b0;
      r_rd_addr0 <= '0;
      r_rd_addr1 <= '0;
      r_rd_addr2 <= '0;
      r_rd_addr3 <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state    <= StRead;
            r_busy     <= 1'b1;
            r_rd_en    <= 1'b1;
            r_row      <= w_nxt_row;
            r_col      <= w_nxt_col;
            r_rd_addr0 <= w_base;
            r_rd_addr1 <= w_base + 1'b1;
            r_rd_addr2 <= w_base + RD_ADDR_W'(IN_DIM);
            r_rd_addr3 <= w_base + RD_ADDR_W'(IN_DIM + 1);
          end
        end
        StRead: begin
          r_state <= StWait;
          r_lat   <= '0;
        end
        StWait: begin
          // Read data is valid only in the final latency cycle.
          if (r_lat == LAT_W'(RD_LAT - 1)) begin
            r_state   <= StWrite;
            r_wr_en   <= 1'b1;
            r_wr_addr <= WR_ADDR_W'(OUT_DIM * 32'(r_row) + 32'(r_col));
            r_wr_data <= w_wr_val;
          end else begin
            r_lat <= r_lat + 1'b1;
          end
        end
        StWrite: begin
          if (w_last_win) begin
            r_state <= StDone;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state    <= StRead;
            r_rd_en    <= 1'b1;
            r_row      <= w_nxt_row;
            r_col      <= w_nxt_col;
            r_rd_addr0 <= w_base;
            r_rd_addr1 <= w_base + 1'b1;
            r_rd_addr2 <= w_base + RD_ADDR_W'(IN_DIM);
            r_rd_addr3 <= w_base + RD_ADDR_W'(IN_DIM + 1);
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_rd_en    = r_rd_en;
  assign o_rd_addr0 = r_rd_addr0;
  assign o_rd_addr1 = r_rd_addr1;
  assign o_rd_addr2 = r_rd_addr2;
  assign o_rd_addr3 = r_rd_addr3;
  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;

endmodule
